// File: rtl/fft64_pkg.sv
// Shared definitions for the 64-point FFT twiddle path: geometry, row index,
// frame FSM states and the quarter-wave cosine table (Q8, 256 = 1.0).
package fft64_pkg;
  localparam int LANE_W = 10;
  localparam int LANES  = 8;
  localparam int VEC_W  = 80;
  localparam int ROWS   = 8;

  typedef logic [2:0] row_t;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // round(256*cos(2*pi*i/64)) for i = 0..16
  function automatic logic signed [9:0] cos_tab(input logic [4:0] i);
    case (i)
      5'd0:  cos_tab = 10'sd256;
      5'd1:  cos_tab = 10'sd255;
      5'd2:  cos_tab = 10'sd251;
      5'd3:  cos_tab = 10'sd245;
      5'd4:  cos_tab = 10'sd237;
      5'd5:  cos_tab = 10'sd226;
      5'd6:  cos_tab = 10'sd213;
      5'd7:  cos_tab = 10'sd198;
      5'd8:  cos_tab = 10'sd181;
      5'd9:  cos_tab = 10'sd162;
      5'd10: cos_tab = 10'sd142;
      5'd11: cos_tab = 10'sd121;
      5'd12: cos_tab = 10'sd98;
      5'd13: cos_tab = 10'sd74;
      5'd14: cos_tab = 10'sd50;
      5'd15: cos_tab = 10'sd25;
      default: cos_tab = 10'sd0;
    endcase
  endfunction
endpackage

// File: rtl/fft64_twiddle_ctrl_multi_core.sv
// Combinational W64 twiddle multiplier: lane k of a row is multiplied by
// W64^(counter*k); products are floored to Q8 and saturated to 10 bits.
module multi_core
  import fft64_pkg::*;
(
  input  logic [5:0]       counter,
  input  logic [VEC_W-1:0] in_re,
  input  logic [VEC_W-1:0] in_im,
  output logic [VEC_W-1:0] out_re,
  output logic [VEC_W-1:0] out_im
);

  function automatic logic [LANE_W-1:0] sat10(input logic signed [20:0] p);
    if (p > 21'sd511)       sat10 = 10'h1ff;
    else if (p < -21'sd512) sat10 = 10'h200;
    else                    sat10 = p[LANE_W-1:0];
  endfunction

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [5:0]               n;
    logic [4:0]               mc;
    logic signed [9:0]        wr, ws;
    logic signed [LANE_W-1:0] a, b;
    logic signed [20:0]       pr, pi;

    assign n  = counter * 6'(k);
    assign mc = 5'd16 - {1'b0, n[3:0]};
    assign a  = in_re[k*LANE_W +: LANE_W];
    assign b  = in_im[k*LANE_W +: LANE_W];

    // quadrant unfold of cos/sin from the 0..90 degree table
    always_comb begin
      wr = '0;
      ws = '0;
      case (n[5:4])
        2'd0: begin wr =  cos_tab({1'b0, n[3:0]}); ws =  cos_tab(mc); end
        2'd1: begin wr = -cos_tab(mc);             ws =  cos_tab({1'b0, n[3:0]}); end
        2'd2: begin wr = -cos_tab({1'b0, n[3:0]}); ws = -cos_tab(mc); end
        default: begin wr = cos_tab(mc);           ws = -cos_tab({1'b0, n[3:0]}); end
      endcase
    end

    // (a + jb) * (wr - j ws)
    assign pr = 21'(a) * 21'(wr) + 21'(b) * 21'(ws);
    assign pi = 21'(b) * 21'(wr) - 21'(a) * 21'(ws);

    assign out_re[k*LANE_W +: LANE_W] = sat10(pr >>> 8);
    assign out_im[k*LANE_W +: LANE_W] = sat10(pi >>> 8);
  end

endmodule

// File: rtl/fft64_twiddle_ctrl.sv
// Row sequencer for the W64 twiddle stage: frame alignment FSM, row counter,
// twiddle select and a single valid/ready output register.
module fft64_twiddle_ctrl #(
  parameter int ROWS   = 8,
  parameter int VEC_W  = 80,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [VEC_W-1:0]  in_re,
  input  logic [VEC_W-1:0]  in_im,
  input  logic              bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eof,
  output logic [2:0]        out_row,
  output logic [VEC_W-1:0]  out_re,
  output logic [VEC_W-1:0]  out_im,
  output logic              sync_err,
  input  logic              clr_err,
  output logic [FCNT_W-1:0] frames_done
);
  import fft64_pkg::*;

  localparam row_t LAST = row_t'(ROWS - 1);

  state_t           st;
  row_t             row, beat_row;
  logic             byp_q;
  logic             acc, issue, resync;
  logic [5:0]       cnt;
  logic [VEC_W-1:0] mre, mim;

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  // IDLE beats without SOF are accepted but never issued
  assign issue    = acc && (in_sof || st == ST_RUN);
  assign resync   = acc && in_sof && st == ST_RUN && row != '0;
  assign beat_row = in_sof ? '0 : row;
  assign cnt      = byp_q ? 6'd0 : {3'b000, beat_row};

  multi_core u_mc (
    .counter (cnt),
    .in_re   (in_re),
    .in_im   (in_im),
    .out_re  (mre),
    .out_im  (mim)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= ST_IDLE;
      row         <= '0;
      byp_q       <= 1'b0;
      out_valid   <= 1'b0;
      out_re      <= '0;
      out_im      <= '0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      out_row     <= '0;
      sync_err    <= 1'b0;
      frames_done <= '0;
    end else begin
      if (issue) begin
        out_valid <= 1'b1;
        out_re    <= mre;
        out_im    <= mim;
        out_sof   <= (beat_row == '0);
        out_eof   <= (beat_row == LAST);
        out_row   <= beat_row;
        if (in_sof) byp_q <= bypass;
        if (beat_row == LAST) begin
          st          <= ST_IDLE;
          row         <= '0;
          frames_done <= frames_done + 1'b1;
        end else begin
          st  <= ST_RUN;
          row <= beat_row + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (resync)       sync_err <= 1'b1;
      else if (clr_err) sync_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft64_twiddle_ctrl.sv
// Scoreboard bench: stimulus pushes expected rows from a real-arithmetic
// twiddle model; an independent monitor pops on every output handshake.
module tb_fft64_twiddle_ctrl;
  logic        clk, rst, in_valid, in_ready, in_sof, bypass;
  logic [79:0] in_re, in_im, out_re, out_im;
  logic        out_valid, out_ready, out_sof, out_eof, sync_err, clr_err;
  logic [2:0]  out_row;
  logic [15:0] frames_done;

  fft64_twiddle_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .in_re(in_re), .in_im(in_im), .bypass(bypass),
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
    .out_eof(out_eof), .out_row(out_row), .out_re(out_re), .out_im(out_im),
    .sync_err(sync_err), .clr_err(clr_err), .frames_done(frames_done)
  );

  typedef struct {
    logic [79:0] re, im;
    logic        sof, eof;
    logic [2:0]  row;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0, n_pass = 0;
  bit          m_in = 0, m_byp = 0, m_err = 0;
  int          m_row = 0;
  logic [15:0] m_frames = '0;
  bit          rnd_or = 0, hold_low = 0, last_acc;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int rnd_int(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic logic [9:0] sat10(input int p);
    if (p > 511)  return 10'h1ff;
    if (p < -512) return 10'h200;
    return p[9:0];
  endfunction

  // x_k * exp(-j*2*pi*r*k/64) with Q8 coefficients, floored and saturated
  task automatic twiddle(input logic [79:0] re, im, input int r,
                         output logic [79:0] ore, oim);
    for (int k = 0; k < 8; k++) begin
      int a, b, wr, ws;
      real th;
      a  = int'($signed(re[k*10 +: 10]));
      b  = int'($signed(im[k*10 +: 10]));
      th = 6.283185307179586 * real'((r * k) % 64) / 64.0;
      wr = rnd_int(256.0 * $cos(th));
      ws = rnd_int(256.0 * $sin(th));
      ore[k*10 +: 10] = sat10((a * wr + b * ws) >>> 8);
      oim[k*10 +: 10] = sat10((b * wr - a * ws) >>> 8);
    end
  endtask

  task automatic model_accept(input bit sof, byp, input logic [79:0] re, im, output bit set);
    exp_t e;
    set = 0;
    if (sof) begin
      if (m_in && m_row != 0) set = 1;
      m_in = 1; m_row = 0; m_byp = byp;
    end
    if (m_in) begin
      e.sof = (m_row == 0);
      e.eof = (m_row == 7);
      e.row = 3'(m_row);
      twiddle(re, im, m_byp ? 0 : m_row, e.re, e.im);
      q.push_back(e);
      if (m_row == 7) begin m_frames++; m_in = 0; m_row = 0; end
      else m_row++;
    end
  endtask

  task automatic step(input bit v, sof, byp, input logic [79:0] re, im, input bit clr, r);
    bit set;
    in_valid = v; in_sof = sof; bypass = byp; in_re = re; in_im = im;
    clr_err = clr; rst = r;
    out_ready = hold_low ? 1'b0 : (rnd_or ? ($urandom_range(0, 3) != 0) : 1'b1);
    #1;
    last_acc = !r && v && in_ready;
    if (r) begin
      q.delete(); m_in = 0; m_row = 0; m_byp = 0; m_err = 0; m_frames = '0;
    end else begin
      set = 0;
      if (last_acc) model_accept(sof, byp, re, im, set);
      m_err = set ? 1'b1 : (clr ? 1'b0 : m_err);
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit clr = 0);
    step(0, 0, 0, '0, '0, clr, 0);
  endtask

  task automatic send_beat(input bit sof, byp, input logic [79:0] re, im, input bit clr = 0);
    int tries = 0;
    do begin
      step(1, sof, byp, re, im, clr, 0);
      tries++;
    end while (!last_acc && tries < 60);
    if (!last_acc) begin
      n_chk++;
      $display("FAIL accept_timeout: beat not accepted after %0d cycles", tries);
    end
  endtask

  task automatic rnd_vec(output logic [79:0] v);
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    v = t[79:0];
  endtask

  // rows first..last of a frame; row 0 carries SOF
  task automatic send_rows(input bit byp, input int first, last, input bit rnd,
                           input logic [9:0] cre);
    logic [79:0] re, im;
    for (int r = first; r <= last; r++) begin
      if (rnd) begin rnd_vec(re); rnd_vec(im); end
      else begin re = {8{cre}}; im = '0; end
      if (rnd_or && $urandom_range(0, 3) == 0) idle();
      send_beat(r == 0, byp, re, im);
    end
  endtask

  task automatic chk_reset();
    chk("rst_out_valid", 96'(out_valid), 96'(0));
    chk("rst_out_re", 96'(out_re), 96'(0));
    chk("rst_out_im", 96'(out_im), 96'(0));
    chk("rst_sof_eof_row", 96'({out_sof, out_eof, out_row}), 96'(0));
    chk("rst_sync_err", 96'(sync_err), 96'(0));
    chk("rst_frames_done", 96'(frames_done), 96'(0));
    chk("rst_in_ready", 96'(in_ready), 96'(1));
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_frames_done"}, 96'(frames_done), 96'(m_frames));
    chk({tag, "_sync_err"}, 96'(sync_err), 96'(m_err));
  endtask

  // monitor: compares on every output transfer, independent of stimulus
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && out_valid && out_ready) begin
        n_chk++;
        if (q.size() == 0) begin
          $display("FAIL out_unexpected: row %0d re %h with nothing expected", out_row, out_re);
        end else begin
          e = q.pop_front();
          if (out_re === e.re && out_im === e.im && out_sof === e.sof &&
              out_eof === e.eof && out_row === e.row) n_pass++;
          else $display("FAIL out_row%0d: got re %h im %h sof %b eof %b row %0d, expected re %h im %h sof %b eof %b row %0d",
                        e.row, out_re, out_im, out_sof, out_eof, out_row,
                        e.re, e.im, e.sof, e.eof, e.row);
        end
      end
    end
  end

  initial begin
    logic [79:0] re, im;
    logic [15:0] f0;
    int ab;
    in_valid = 0; in_sof = 0; bypass = 0; in_re = '0; in_im = '0;
    clr_err = 0; out_ready = 1; rst = 1;
    @(negedge clk);
    step(0, 0, 0, '0, '0, 0, 1);
    step(0, 0, 0, '0, '0, 0, 1);
    chk_reset();

    // bypass then twiddle frame on constant data
    send_rows(1, 0, 7, 0, 10'h040);
    idle(); idle();
    chk_status("bypass");
    send_rows(0, 0, 7, 0, 10'h040);
    idle(); idle();
    chk_status("twiddle");

    // backpressure after row 2
    send_rows(0, 0, 2, 1, '0);
    hold_low = 1;
    rnd_vec(re); rnd_vec(im);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, re, im, 0, 0);
      chk("bp_in_ready", 96'(in_ready), 96'(0));
      chk("bp_hold_row", 96'({out_valid, out_row}), 96'({1'b1, 3'd2}));
      chk("bp_hold_re", 96'(out_re), 96'(q[0].re));
    end
    hold_low = 0;
    send_rows(0, 3, 7, 1, '0);
    idle(); idle();
    chk_status("bp");

    // garbage before SOF
    for (int i = 0; i < 5; i++) begin
      rnd_vec(re); rnd_vec(im);
      step(1, 0, 0, re, im, 0, 0);
      chk("garbage_no_valid", 96'(out_valid), 96'(0));
    end
    send_rows(0, 0, 7, 1, '0);
    idle();
    chk_status("garbage");

    // resync on row 4
    f0 = m_frames;
    send_rows(0, 0, 3, 1, '0);
    rnd_vec(re); rnd_vec(im);
    send_beat(1, 1, re, im);
    idle();
    chk("resync_err", 96'(sync_err), 96'(1));
    chk("resync_frames_same", 96'(frames_done), 96'(f0));
    send_rows(1, 1, 7, 1, '0);
    idle();
    chk("resync_frames_inc", 96'(frames_done), 96'(f0 + 16'd1));
    idle(1);
    chk("clr_err", 96'(sync_err), 96'(0));
    send_rows(0, 0, 2, 1, '0);
    rnd_vec(re); rnd_vec(im);
    send_beat(1, 0, re, im, 1);
    chk("set_beats_clr", 96'(sync_err), 96'(1));
    send_rows(0, 1, 7, 1, '0);
    idle(1); idle();
    chk_status("resync");

    // reset on row 3
    send_rows(0, 0, 2, 1, '0);
    rnd_vec(re); rnd_vec(im);
    step(1, 0, 0, re, im, 0, 1);
    chk_reset();
    idle();
    send_rows(0, 0, 7, 1, '0);
    idle(); idle();
    chk_status("post_rst");

    // randomized frames with backpressure, gaps, garbage and aborts
    rnd_or = 1;
    for (int f = 0; f < 24; f++) begin
      if ($urandom_range(0, 4) == 0)
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
          rnd_vec(re); rnd_vec(im);
          send_beat(0, 0, re, im);
        end
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 6)) : 7;
      send_rows(1'($urandom_range(0, 1)), 0, ab, 1, '0);
      if (($urandom_range(0, 3)) == 0) idle(1'($urandom_range(0, 1)));
    end
    rnd_or = 0;
    for (int i = 0; i < 5; i++) idle();
    chk("drain_empty", 96'(q.size()), 96'(0));
    chk_status("random");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
